hazard_sequencer: RTL and testbench
===================================

HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 Parameter MD_TIMEOUT, default 64, sets the maximum MD_WAIT cycles before abort; legal range 2..255; used only with MD_TIMEOUT_EN.
REQ-002 CLK  input  1  the single clock; all state updates on the rising edge.
REQ-003 RST  input  1  reset, asynchronous assert, active-low.
REQ-004 ID_RS1, ID_RS2  input  5 each  source register indices of the instruction in ID.
REQ-005 ID_USES_RS1, ID_USES_RS2  input  1 each  ID instruction actually reads RS1 / RS2.
REQ-006 EX_RD  input  5  destination index of the instruction in EX.
REQ-007 EX_MEM_READ  input  1  EX instruction is a load.
REQ-008 EX_REDIRECT  input  1  taken branch or jump resolved in EX.
REQ-009 EX_MULDIV  input  1  EX instruction is a multi-cycle M-extension op.
REQ-010 MD_DONE  input  1  multiply/divide unit result valid this cycle.
REQ-011 MD_START  output  1  one-cycle start pulse to the multiply/divide unit.
REQ-012 MD_ABORT  output  1  one-cycle abort pulse to the multiply/divide unit.
REQ-013 PC_STALL, IF_ID_STALL, ID_EX_STALL  output  1 each  hold the PC / pipeline register.
REQ-014 IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH  output  1 each  load a bubble into the pipeline register.
REQ-015 BUSY  output  1  state is MD_WAIT.
REQ-016 MD_ERR  output  1  one-cycle timeout flag.

Function
REQ-017 FSM states: RUN, MD_WAIT; all outputs combinational from state and inputs.
REQ-018 RUN, EX_MULDIV=1, MD_DONE=0: MD_START=1, PC_STALL=IF_ID_STALL=ID_EX_STALL=1, EX_MEM_FLUSH=1; next state MD_WAIT; wait counter cleared.
REQ-019 RUN, EX_MULDIV=1, MD_DONE=1 (single-cycle op): MD_START=1, no stall, no flush; stay RUN.
REQ-020 MD_WAIT, MD_DONE=0: all three stalls and EX_MEM_FLUSH held at 1; MD_START=0; counter increments by 1 per cycle, saturating at 255.
REQ-021 MD_WAIT, MD_DONE=1: stalls and EX_MEM_FLUSH are 0 in that cycle so EX/MEM captures the result; next state RUN.
REQ-022 RUN, EX_REDIRECT=1, EX_MULDIV=0: IF_ID_FLUSH=ID_EX_FLUSH=1 and no stalls, and load-use detection is suppressed.
REQ-023 Load-use: in RUN with EX_MEM_READ=1, EX_RD!=0, and a used source index equal to EX_RD, the block asserts PC_STALL=IF_ID_STALL=1 and ID_EX_FLUSH=1 for exactly that cycle.
REQ-024 Load-use never matches EX_RD=0, and never matches a source whose USES bit is 0.
REQ-025 Priority when inputs coincide: EX_MULDIV > EX_REDIRECT > load-use; EX_REDIRECT and load-use inputs are ignored in MD_WAIT.
REQ-026 No stall or flush output is asserted in RUN unless one of REQ-018..REQ-023 applies.

Reset
REQ-027 RST=0 asynchronously forces state RUN, counter 0, and every output 0, regardless of other inputs.
REQ-028 Reset mid-MD_WAIT abandons the operation without an MD_ABORT pulse; the first post-reset cycle is RUN.

Configuration
REQ-029 Macro MD_TIMEOUT_EN defined: in MD_WAIT with MD_DONE=0 and counter = MD_TIMEOUT-1, the block asserts MD_ERR=1, MD_ABORT=1, and EX_MEM_FLUSH=1, releases all stalls, and returns to RUN.
REQ-030 Macro MD_TIMEOUT_EN defined: MD_DONE takes precedence over timeout in the same cycle.
REQ-031 Macro MD_TIMEOUT_EN undefined: MD_WAIT persists until MD_DONE, MD_ERR=MD_ABORT=0 constant, and no timeout logic is present.

Verification
REQ-032 Load-use: EX_MEM_READ=1, EX_RD=5, ID_RS2=5, ID_USES_RS2=1 -> one cycle of PC_STALL=IF_ID_STALL=ID_EX_FLUSH=1; the same stimulus with EX_RD=0 -> all outputs 0.
REQ-033 Divide: EX_MULDIV=1 at cycle T, MD_DONE=1 at T+33 -> MD_START only at T, stalls and EX_MEM_FLUSH=1 for T..T+32, all 0 at T+33, BUSY=1 for T+1..T+33.
REQ-034 Coincidence: EX_MULDIV=1, EX_REDIRECT=1, load-use hit in the same cycle -> MD_WAIT entered with IF_ID_FLUSH=ID_EX_FLUSH=0; MD_DONE the same cycle as MD_START -> no stall.
REQ-035 Timeout (MD_TIMEOUT_EN, MD_TIMEOUT=8): EX_MULDIV at T, no MD_DONE -> MD_ERR=MD_ABORT=1 at T+8, state RUN at T+9; without the macro -> BUSY remains 1 at T+100.
REQ-036 Reset: RST=0 asserted at T+5 during MD_WAIT -> outputs 0 immediately with no clock edge; after release -> RUN, no MD_ABORT.

Source files
------------

// File: rtl/hazard_sequencer.sv
// ----------------------------------------------------------------------------
// hazard_sequencer
//
// Purpose: pipeline hazard control for a 5-stage in-order core. It covers
// three things: load-use interlocks, flushes after a taken branch or jump
// resolved in EX, and sequencing of a multi-cycle multiply/divide unit through
// a RUN / MD_WAIT state machine.
//
// Optional feature: define MD_TIMEOUT_EN to enable the multiply/divide timeout.
// When it is enabled, an operation that runs for MD_TIMEOUT wait cycles is
// aborted and flagged.
//
// Parameters:
//   MD_TIMEOUT        maximum MD_WAIT cycles before abort (2..255)
//
// Ports:
//   i_clk             clock; all state changes on the rising edge
//   i_rst_n           asynchronous active-low reset
//   i_id_rs1/rs2      source register indices of the instruction in ID
//   i_id_uses_rs1/2   ID instruction actually reads that source
//   i_ex_rd           destination index of the instruction in EX
//   i_ex_mem_read     EX instruction is a load
//   i_ex_redirect     taken branch or jump resolved in EX
//   i_ex_muldiv       EX instruction is a multi-cycle M-extension op
//   i_md_done         multiply/divide result valid this cycle
//   o_md_start        one-cycle start pulse to the multiply/divide unit
//   o_md_abort        one-cycle abort pulse to the multiply/divide unit
//   o_pc_stall        hold the PC
//   o_if_id_stall     hold the IF/ID register
//   o_id_ex_stall     hold the ID/EX register
//   o_if_id_flush     bubble into the IF/ID register
//   o_id_ex_flush     bubble into the ID/EX register
//   o_ex_mem_flush    bubble into the EX/MEM register
//   o_busy            state is MD_WAIT
//   o_md_err          one-cycle timeout flag
// ----------------------------------------------------------------------------
module hazard_sequencer #(
    parameter int unsigned MD_TIMEOUT = 64
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_uses_rs1,
    input  logic       i_id_uses_rs2,
    input  logic [4:0] i_ex_rd,
    input  logic       i_ex_mem_read,
    input  logic       i_ex_redirect,
    input  logic       i_ex_muldiv,
    input  logic       i_md_done,
    output logic       o_md_start,
    output logic       o_md_abort,
    output logic       o_pc_stall,
    output logic       o_if_id_stall,
    output logic       o_id_ex_stall,
    output logic       o_if_id_flush,
    output logic       o_id_ex_flush,
    output logic       o_ex_mem_flush,
    output logic       o_busy,
    output logic       o_md_err
);

    // Reject an illegal timeout setting at elaboration time.
    if (MD_TIMEOUT < 2 || MD_TIMEOUT > 255) begin : g_md_timeout_range
        $error("hazard_sequencer: MD_TIMEOUT must be in 2..255");
    end

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_WAIT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic w_md_start;
    logic w_md_abort;
    logic w_pc_stall;
    logic w_if_id_stall;
    logic w_id_ex_stall;
    logic w_if_id_flush;
    logic w_id_ex_flush;
    logic w_ex_mem_flush;
    logic w_busy;
    logic w_md_err;

    // A load in EX whose destination is read by ID. x0 is hard-wired to zero,
    // so it can never create a dependency.
    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_load_use;

    assign w_rs1_hit  = i_id_uses_rs1 && (i_id_rs1 == i_ex_rd);
    assign w_rs2_hit  = i_id_uses_rs2 && (i_id_rs2 == i_ex_rd);
    assign w_load_use = i_ex_mem_read && (i_ex_rd != 5'd0) && (w_rs1_hit || w_rs2_hit);

`ifdef MD_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(MD_TIMEOUT - 1);

    // Counts MD_WAIT cycles that have no MD_DONE. It is cleared when the
    // operation starts and saturates so that it can never wrap.
    logic [7:0] r_wait_cnt;
    logic [7:0] w_wait_cnt_next;
    logic       w_timeout;

    assign w_timeout = (r_wait_cnt == TIMEOUT_LAST);
`endif

    always_comb begin
        w_state_next   = r_state;
        w_md_start     = 1'b0;
        w_md_abort     = 1'b0;
        w_pc_stall     = 1'b0;
        w_if_id_stall  = 1'b0;
        w_id_ex_stall  = 1'b0;
        w_if_id_flush  = 1'b0;
        w_id_ex_flush  = 1'b0;
        w_ex_mem_flush = 1'b0;
        w_busy         = 1'b0;
        w_md_err       = 1'b0;
`ifdef MD_TIMEOUT_EN
        w_wait_cnt_next = r_wait_cnt;
`endif

        unique case (r_state)
            ST_RUN: begin
                // The priority is: multiply/divide, then redirect, then load-use.
                if (i_ex_muldiv) begin
                    w_md_start = 1'b1;
                    // If the result is ready in the same cycle, the op acts
                    // like a normal ALU op and nothing is held.
                    if (!i_md_done) begin
                        w_pc_stall     = 1'b1;
                        w_if_id_stall  = 1'b1;
                        w_id_ex_stall  = 1'b1;
                        w_ex_mem_flush = 1'b1;
                        w_state_next   = ST_MD_WAIT;
`ifdef MD_TIMEOUT_EN
                        w_wait_cnt_next = 8'd0;
`endif
                    end
                end else if (i_ex_redirect) begin
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = 1'b1;
                end else if (w_load_use) begin
                    w_pc_stall    = 1'b1;
                    w_if_id_stall = 1'b1;
                    w_id_ex_flush = 1'b1;
                end
            end

            ST_MD_WAIT: begin
                w_busy = 1'b1;
                // This branch holds no stall or flush, so in this cycle the
                // EX/MEM register captures the unit's result.
                if (i_md_done) begin
                    w_state_next = ST_RUN;
`ifdef MD_TIMEOUT_EN
                end else if (w_timeout) begin
                    w_md_err       = 1'b1;
                    w_md_abort     = 1'b1;
                    w_ex_mem_flush = 1'b1;
                    w_state_next   = ST_RUN;
`endif
                end else begin
                    w_pc_stall     = 1'b1;
                    w_if_id_stall  = 1'b1;
                    w_id_ex_stall  = 1'b1;
                    w_ex_mem_flush = 1'b1;
`ifdef MD_TIMEOUT_EN
                    if (r_wait_cnt != 8'hFF) begin
                        w_wait_cnt_next = r_wait_cnt + 8'd1;
                    end
`endif
                end
            end

            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

`ifdef MD_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wait_cnt <= 8'd0;
        end else begin
            r_wait_cnt <= w_wait_cnt_next;
        end
    end
`endif

    // The outputs are combinational from the inputs. While reset is asserted
    // they are gated off, so a live hazard pattern on the inputs cannot leak
    // through.
    assign o_md_start     = i_rst_n & w_md_start;
    assign o_md_abort     = i_rst_n & w_md_abort;
    assign o_pc_stall     = i_rst_n & w_pc_stall;
    assign o_if_id_stall  = i_rst_n & w_if_id_stall;
    assign o_id_ex_stall  = i_rst_n & w_id_ex_stall;
    assign o_if_id_flush  = i_rst_n & w_if_id_flush;
    assign o_id_ex_flush  = i_rst_n & w_id_ex_flush;
    assign o_ex_mem_flush = i_rst_n & w_ex_mem_flush;
    assign o_busy         = i_rst_n & w_busy;
    assign o_md_err       = i_rst_n & w_md_err;

endmodule

// File: tb/tb_hazard_sequencer.sv
// ----------------------------------------------------------------------------
// tb_hazard_sequencer
//
// Scoreboard bench for hazard_sequencer. Each stimulus cycle pushes the
// expected output vector into a queue. A checker process pops one entry on
// every falling edge and compares it with the DUT outputs. Build the bench
// with or without MD_TIMEOUT_EN, so that it matches the RTL build.
// ----------------------------------------------------------------------------
module tb_hazard_sequencer;

    localparam int unsigned TIMEOUT = 8;
`ifdef MD_TIMEOUT_EN
    localparam int DIV_LAT = 5;   // must finish before the timeout fires
`else
    localparam int DIV_LAT = 33;
`endif

    // Bit positions in the packed output vector
    localparam logic [9:0] B_START = 10'b10_0000_0000;
    localparam logic [9:0] B_ABORT = 10'b01_0000_0000;
    localparam logic [9:0] B_PCST  = 10'b00_1000_0000;
    localparam logic [9:0] B_IFST  = 10'b00_0100_0000;
    localparam logic [9:0] B_IDST  = 10'b00_0010_0000;
    localparam logic [9:0] B_IFFL  = 10'b00_0001_0000;
    localparam logic [9:0] B_IDFL  = 10'b00_0000_1000;
    localparam logic [9:0] B_EMFL  = 10'b00_0000_0100;
    localparam logic [9:0] B_BUSY  = 10'b00_0000_0010;
    localparam logic [9:0] B_ERR   = 10'b00_0000_0001;

    localparam logic [9:0] E_NONE    = 10'd0;
    localparam logic [9:0] E_LOADUSE = B_PCST | B_IFST | B_IDFL;
    localparam logic [9:0] E_REDIR   = B_IFFL | B_IDFL;
    localparam logic [9:0] E_MDSTART = B_START | B_PCST | B_IFST | B_IDST | B_EMFL;
    localparam logic [9:0] E_MDWAIT  = B_PCST | B_IFST | B_IDST | B_EMFL | B_BUSY;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2;
    logic       ex_mem_read, ex_redirect, ex_muldiv, md_done;
    logic       md_start, md_abort, pc_stall, if_id_stall, id_ex_stall;
    logic       if_id_flush, id_ex_flush, ex_mem_flush, busy, md_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [9:0] exp_q[$];
    string      tag_q[$];

    hazard_sequencer #(.MD_TIMEOUT(TIMEOUT)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_id_rs1       (id_rs1),
        .i_id_rs2       (id_rs2),
        .i_id_uses_rs1  (id_uses_rs1),
        .i_id_uses_rs2  (id_uses_rs2),
        .i_ex_rd        (ex_rd),
        .i_ex_mem_read  (ex_mem_read),
        .i_ex_redirect  (ex_redirect),
        .i_ex_muldiv    (ex_muldiv),
        .i_md_done      (md_done),
        .o_md_start     (md_start),
        .o_md_abort     (md_abort),
        .o_pc_stall     (pc_stall),
        .o_if_id_stall  (if_id_stall),
        .o_id_ex_stall  (id_ex_stall),
        .o_if_id_flush  (if_id_flush),
        .o_id_ex_flush  (id_ex_flush),
        .o_ex_mem_flush (ex_mem_flush),
        .o_busy         (busy),
        .o_md_err       (md_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] outs();
        return {md_start, md_abort, pc_stall, if_id_stall, id_ex_stall,
                if_id_flush, id_ex_flush, ex_mem_flush, busy, md_err};
    endfunction

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end else begin
            $display("ok   %s: %h", tag, act);
        end
    endtask

    // Scoreboard checker: one expected vector is compared per falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                check(tag_q.pop_front(), {6'd0, outs()}, {6'd0, exp_q.pop_front()});
            end
        end
    end

    // Drives one cycle of stimulus just after a rising edge and queues its
    // expected outputs.
    task automatic cyc(input string tag, input logic mul, input logic done,
                       input logic redir, input logic mrd, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [9:0] exp);
        ex_muldiv   = mul;
        md_done     = done;
        ex_redirect = redir;
        ex_mem_read = mrd;
        ex_rd       = rd;
        id_rs1      = rs1;
        id_uses_rs1 = u1;
        id_rs2      = rs2;
        id_uses_rs2 = u2;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input logic [9:0] exp);
        cyc(tag, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, exp);
    endtask

    initial begin
        // Reset with a live load-use and muldiv pattern on the inputs
        rst_n = 1'b0;
        ex_muldiv = 1'b1; md_done = 1'b0; ex_redirect = 1'b1;
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
        id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
        #3;
        check("reset_outs", {6'd0, outs()}, 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        idle("idle", E_NONE);
        // Load-use cases
        cyc("lu_rs2",      0, 0, 0, 1, 5'd5, 5'd1, 1, 5'd5, 1, E_LOADUSE);
        idle("lu_release", E_NONE);
        cyc("lu_rd0",      0, 0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 1, E_NONE);
        cyc("lu_rs1_unused", 0, 0, 0, 1, 5'd9, 5'd9, 0, 5'd3, 1, E_NONE);
        cyc("lu_rs1",      0, 0, 0, 1, 5'd9, 5'd9, 1, 5'd3, 0, E_LOADUSE);
        cyc("lu_no_load",  0, 0, 0, 0, 5'd9, 5'd9, 1, 5'd9, 1, E_NONE);
        // Redirect, and redirect taking priority over load-use
        cyc("redirect",    0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_REDIR);
        cyc("redir_lu",    0, 0, 1, 1, 5'd7, 5'd7, 1, 5'd7, 1, E_REDIR);
        // Single-cycle muldiv
        cyc("md_1cycle",   1, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, B_START);
        idle("after_1cyc", E_NONE);

        // Divide: start at T, done at T+DIV_LAT. The muldiv, redirect and
        // load-use inputs are held high while waiting and must be ignored.
        cyc("div_start",   1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_MDSTART);
        for (int i = 1; i < DIV_LAT; i++)
            cyc($sformatf("div_wait%0d", i), 1, 0, 1, 1, 5'd4, 5'd4, 1, 5'd4, 1, E_MDWAIT);
        cyc("div_done",    1, 1, 1, 1, 5'd4, 5'd4, 1, 5'd4, 1, B_BUSY);
        idle("div_after",  E_NONE);

        // Coincidence: muldiv beats redirect and load-use
        cyc("coin_start",  1, 0, 1, 1, 5'd6, 5'd6, 1, 5'd6, 1, E_MDSTART);
        cyc("coin_wait",   0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_MDWAIT);
        cyc("coin_done",   0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, B_BUSY);
        cyc("coin_1cyc",   1, 1, 1, 1, 5'd6, 5'd6, 1, 5'd6, 1, B_START);
        idle("coin_after", E_NONE);

        // Timeout behaviour
        cyc("to_start",    1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_MDSTART);
`ifdef MD_TIMEOUT_EN
        for (int i = 1; i < int'(TIMEOUT); i++)
            idle($sformatf("to_wait%0d", i), E_MDWAIT);
        idle("to_abort",   B_ERR | B_ABORT | B_EMFL | B_BUSY);
        idle("to_run",     E_NONE);
        // MD_DONE in the cycle where the timeout would fire wins
        cyc("pr_start",    1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_MDSTART);
        for (int i = 1; i < int'(TIMEOUT); i++)
            idle($sformatf("pr_wait%0d", i), E_MDWAIT);
        cyc("pr_done",     0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, B_BUSY);
        idle("pr_run",     E_NONE);
`else
        for (int i = 1; i < 100; i++)
            idle($sformatf("to_wait%0d", i), E_MDWAIT);
        idle("busy_t100",  E_MDWAIT);
        cyc("to_done",     0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, B_BUSY);
        idle("to_run",     E_NONE);
`endif

        // Reset in the middle of MD_WAIT: start at T, reset at T+5
        cyc("rs_start",    1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_MDSTART);
        for (int i = 1; i < 5; i++)
            idle($sformatf("rs_wait%0d", i), E_MDWAIT);
        cyc("rs_wait5",    0, 0, 0, 1, 5'd3, 5'd3, 1, 5'd0, 0, E_MDWAIT);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async", {6'd0, outs()}, 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle("post_rst",   E_NONE);
        cyc("post_rst_lu", 0, 0, 0, 1, 5'd3, 5'd3, 1, 5'd0, 0, E_LOADUSE);
        idle("final",      E_NONE);

        @(negedge clk);
        #1;
        check("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
